// File: rtl/cmos_ddr_wr_pkg.sv
// Shared definitions for the camera-to-DDR write path: FSM encoding, byte-lane order
// and the lane insertion helper used by the DVP packer.
package cmos_ddr_wr_pkg;

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      SKIP      = 2'd1,
      WAIT_VS   = 2'd2,
      CAPTURE   = 2'd3
   } wr_state_t;

   localparam int CNT_W = 12;

   // Arrival order within a word: first DVP byte lands in the most significant lane
   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   function automatic logic [31:0] place_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  value);
      logic [31:0] result;
      result = word;
      case (lane)
         LANE_B0: result[31:24] = value;
         LANE_B1: result[23:16] = value;
         LANE_B2: result[15:8]  = value;
         LANE_B3: result[7:0]   = value;
         default: result        = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/cmos_ddr_wr_dvp_byte_packer.sv
// Packs the registered DVP byte stream into 32-bit words, counting bytes per line and
// dropping anything past the stored line length.
module cmos_ddr_wr_dvp_byte_packer
   import cmos_ddr_wr_pkg::*;
#(
   parameter int MAX_BYTES = 1280
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             line_start,
   input  logic             byte_valid,
   input  logic [7:0]       data,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             word_valid,
   output logic [31:0]      word
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] idx;
   logic             take;

   // The first byte of a line arrives together with the href edge, before the counter clears
   always_comb begin
      idx  = {CNT_W{1'b0}};
      take = 1'b0;
      if (line_start) begin
         idx = {CNT_W{1'b0}};
      end else begin
         idx = byte_cnt;
      end
      take = enable && byte_valid && (idx < MAX_CNT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt   <= {CNT_W{1'b0}};
         word_valid <= 1'b0;
         word       <= 32'h0000_0000;
      end else begin
         if (line_start) begin
            byte_cnt <= CNT_ONE;
         end else if (byte_valid && (byte_cnt != {CNT_W{1'b1}})) begin
            byte_cnt <= byte_cnt + CNT_ONE;
         end
         if (take) begin
            word       <= place_byte(word, idx[1:0], data);
            word_valid <= (idx[1:0] == LANE_B3);
         end else begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cmos_ddr_wr.sv
// Camera write side: samples OV5640 DVP, skips settling frames, packs RGB565 pairs
// into 32-bit DDR write strobes and tracks per-frame line accounting.
module cmos_ddr_wr
   import cmos_ddr_wr_pkg::*;
#(
   parameter int H_PIXELS    = 640,
   parameter int V_LINES     = 480,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        cmos_clk,
   input  logic        cmos_rst,
   input  logic        ddr_init_done,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   output logic        ddr_wren,
   output logic [31:0] ddr_wdata,
   output logic        frame_start,
   output logic        frame_done,
   output logic        line_err
);

   localparam logic [CNT_W-1:0] LINE_BYTES = CNT_W'(2 * H_PIXELS);
   localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_LINES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [7:0]       SKIP_MAX   = 8'(SKIP_FRAMES);

   wr_state_t        state, state_nx;
   logic             vsync_d, vsync_q, href_d, href_q;
   logic [7:0]       data_d;
   logic             vs_rise, vs_fall, href_rise, href_fall;
   logic             start_nx, done_nx, capt, line_end, in_lines;
   logic [7:0]       skip_cnt;
   logic [CNT_W-1:0] line_cnt, byte_cnt;
   logic             word_valid;
   logic [31:0]      word;

   always_ff @(posedge cmos_clk or posedge cmos_rst) begin
      if (cmos_rst) begin
         vsync_d <= 1'b0;
         vsync_q <= 1'b0;
         href_d  <= 1'b0;
         href_q  <= 1'b0;
         data_d  <= 8'h00;
      end else begin
         vsync_d <= cmos_vsync;
         vsync_q <= vsync_d;
         href_d  <= cmos_href;
         href_q  <= href_d;
         data_d  <= cmos_data;
      end
   end

   assign vs_rise   = vsync_d & ~vsync_q;
   assign vs_fall   = ~vsync_d & vsync_q;
   assign href_rise = href_d & ~href_q;
   assign href_fall = ~href_d & href_q;

   // Losing DDR calibration overrides everything and abandons the frame silently
   always_comb begin
      state_nx = state;
      start_nx = 1'b0;
      done_nx  = 1'b0;
      if (!ddr_init_done) begin
         state_nx = WAIT_INIT;
      end else begin
         case (state)
            WAIT_INIT: state_nx = SKIP;
            SKIP: begin
               if (skip_cnt == SKIP_MAX) begin
                  state_nx = WAIT_VS;
               end else begin
                  state_nx = SKIP;
               end
            end
            WAIT_VS: begin
               if (vs_fall) begin
                  state_nx = CAPTURE;
                  start_nx = 1'b1;
               end else begin
                  state_nx = WAIT_VS;
               end
            end
            CAPTURE: begin
               if (vs_rise) begin
                  state_nx = WAIT_VS;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = CAPTURE;
               end
            end
            default: state_nx = WAIT_INIT;
         endcase
      end
   end

   // A vsync rise while href is still high ends the line exactly like an href fall
   always_comb begin
      in_lines = (line_cnt < V_MAX);
      capt     = (state == CAPTURE) && ddr_init_done && !vs_rise;
      line_end = (state == CAPTURE) && ddr_init_done && (href_fall || (vs_rise && href_d));
   end

   always_ff @(posedge cmos_clk or posedge cmos_rst) begin
      if (cmos_rst) begin
         state       <= WAIT_INIT;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         ddr_wren    <= 1'b0;
         ddr_wdata   <= 32'h0000_0000;
         skip_cnt    <= 8'd0;
         line_cnt    <= {CNT_W{1'b0}};
         line_err    <= 1'b0;
      end else begin
         state       <= state_nx;
         frame_start <= start_nx;
         frame_done  <= done_nx;
         ddr_wren    <= word_valid & ddr_init_done;
         if (word_valid && ddr_init_done) begin
            ddr_wdata <= word;
         end
         if (state == WAIT_INIT) begin
            skip_cnt <= 8'd0;
         end else if ((state == SKIP) && vs_rise && (skip_cnt != SKIP_MAX)) begin
            skip_cnt <= skip_cnt + 8'd1;
         end
         if (start_nx) begin
            line_cnt <= {CNT_W{1'b0}};
            line_err <= 1'b0;
         end else if (line_end && in_lines) begin
            line_cnt <= line_cnt + CNT_ONE;
            if (byte_cnt != LINE_BYTES) begin
               line_err <= 1'b1;
            end
         end
      end
   end

   cmos_ddr_wr_dvp_byte_packer #(
      .MAX_BYTES (2 * H_PIXELS)
   ) u_packer (
      .clk        (cmos_clk),
      .rst        (cmos_rst),
      .enable     (capt && in_lines),
      .line_start (href_rise),
      .byte_valid (href_d),
      .data       (data_d),
      .byte_cnt   (byte_cnt),
      .word_valid (word_valid),
      .word       (word)
   );

endmodule
